// File: rtl/frame_run_allocator.sv
// Contiguous-run page-frame allocator: first-fit sequential scan for allocs,
// owner-checked range free, and a full sweep that releases every frame of one owner.
module frame_run_allocator #(
  parameter int NUM_FRAMES = 256,
  parameter int FRAME_BITS = 8,
  parameter int MAX_RUN    = 8,
  parameter int RUN_BITS   = 4,
  parameter int OWNER_BITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  ready,
  input  logic                  alloc_req,
  input  logic [RUN_BITS-1:0]   alloc_len,
  input  logic [OWNER_BITS-1:0] alloc_owner,
  output logic                  alloc_done,
  output logic                  alloc_ok,
  output logic [FRAME_BITS-1:0] alloc_base,
  input  logic                  free_req,
  input  logic [FRAME_BITS-1:0] free_base,
  input  logic [RUN_BITS-1:0]   free_len,
  input  logic [OWNER_BITS-1:0] free_owner,
  output logic                  free_done,
  output logic                  free_ok,
  input  logic                  rel_req,
  input  logic [OWNER_BITS-1:0] rel_owner,
  output logic                  rel_done,
  output logic [FRAME_BITS:0]   rel_count,
  output logic [FRAME_BITS:0]   free_count,
  output logic                  out_of_memory
);

  typedef enum logic [1:0] {IDLE, SCAN, COMMIT, RELEASE} state_t;

  localparam int CW = FRAME_BITS + 1;
  localparam logic [FRAME_BITS-1:0] LAST_FRAME = FRAME_BITS'(NUM_FRAMES - 1);

  state_t                state_q, state_d;
  logic [NUM_FRAMES-1:0] bitmap_q, bitmap_d;
  logic [OWNER_BITS-1:0] tag_q [NUM_FRAMES];
  logic [OWNER_BITS-1:0] tag_d [NUM_FRAMES];
  logic [CW-1:0]         free_count_q, free_count_d;
  logic [FRAME_BITS-1:0] cursor_q, cursor_d;
  logic [FRAME_BITS-1:0] run_start_q, run_start_d;
  logic [RUN_BITS-1:0]   run_cnt_q, run_cnt_d;
  logic [RUN_BITS-1:0]   len_q, len_d;
  logic [OWNER_BITS-1:0] owner_q, owner_d;
  logic                  fit_q, fit_d;
  logic [CW-1:0]         rel_cnt_q, rel_cnt_d;

  logic                  alloc_done_q, alloc_done_d;
  logic                  alloc_ok_q, alloc_ok_d;
  logic [FRAME_BITS-1:0] alloc_base_q, alloc_base_d;
  logic                  free_done_q, free_done_d;
  logic                  free_ok_q, free_ok_d;
  logic                  rel_done_q, rel_done_d;
  logic [CW-1:0]         rel_count_q, rel_count_d;

  logic [CW-1:0]         commit_end, free_start, free_end;
  logic [NUM_FRAMES-1:0] commit_mask, free_mask, free_viol;
  logic                  commit_we, free_valid, alloc_reject, rel_hit, last_frame;
  logic [RUN_BITS-1:0]   run_cnt_inc;

  assign commit_end = CW'(run_start_q) + CW'(len_q);
  assign free_start = CW'(free_base);
  assign free_end   = CW'(free_base) + CW'(free_len);
  assign commit_we  = (state_q == COMMIT) && fit_q;

  // Per-frame range decode for the commit write and the free ownership check.
  generate
    for (genvar gi = 0; gi < NUM_FRAMES; gi++) begin : g_frame
      assign commit_mask[gi] = (CW'(gi) >= CW'(run_start_q)) && (CW'(gi) < commit_end);
      assign free_mask[gi]   = (CW'(gi) >= free_start) && (CW'(gi) < free_end);
      assign free_viol[gi]   = free_mask[gi] && (bitmap_q[gi] || (tag_q[gi] != free_owner));
      assign tag_d[gi]       = (commit_we && commit_mask[gi]) ? owner_q : tag_q[gi];
    end
  endgenerate

  assign free_valid = (free_len != '0) && (free_len <= RUN_BITS'(MAX_RUN)) &&
                      (free_end <= CW'(NUM_FRAMES)) && !(|free_viol);
  assign alloc_reject = (alloc_len == '0) || (alloc_len > RUN_BITS'(MAX_RUN)) ||
                        (CW'(alloc_len) > free_count_q);
  assign rel_hit     = !bitmap_q[cursor_q] && (tag_q[cursor_q] == owner_q);
  assign last_frame  = (cursor_q == LAST_FRAME);
  assign run_cnt_inc = run_cnt_q + RUN_BITS'(1);

  always_comb begin
    state_d      = state_q;
    bitmap_d     = bitmap_q;
    free_count_d = free_count_q;
    cursor_d     = cursor_q;
    run_start_d  = run_start_q;
    run_cnt_d    = run_cnt_q;
    len_d        = len_q;
    owner_d      = owner_q;
    fit_d        = fit_q;
    rel_cnt_d    = rel_cnt_q;
    alloc_done_d = 1'b0;
    alloc_ok_d   = 1'b0;
    alloc_base_d = '0;
    free_done_d  = 1'b0;
    free_ok_d    = 1'b0;
    rel_done_d   = 1'b0;
    rel_count_d  = rel_count_q;

    case (state_q)
      IDLE: begin
        if (rel_req) begin
          owner_d   = rel_owner;
          cursor_d  = '0;
          rel_cnt_d = '0;
          state_d   = RELEASE;
        end else if (free_req) begin
          free_done_d = 1'b1;
          if (free_valid) begin
            bitmap_d     = bitmap_q | free_mask;
            free_count_d = free_count_q + CW'(free_len);
            free_ok_d    = 1'b1;
          end
        end else if (alloc_req) begin
          if (alloc_reject) begin
            alloc_done_d = 1'b1;
          end else begin
            len_d       = alloc_len;
            owner_d     = alloc_owner;
            cursor_d    = '0;
            run_start_d = '0;
            run_cnt_d   = '0;
            state_d     = SCAN;
          end
        end
      end

      SCAN: begin
        cursor_d = cursor_q + FRAME_BITS'(1);
        if (bitmap_q[cursor_q]) begin
          run_cnt_d = run_cnt_inc;
          if (run_cnt_inc == len_q) begin
            fit_d   = 1'b1;
            state_d = COMMIT;
          end else if (last_frame) begin
            fit_d   = 1'b0;
            state_d = COMMIT;
          end
        end else begin
          run_cnt_d   = '0;
          run_start_d = cursor_q + FRAME_BITS'(1);
          if (last_frame) begin
            fit_d   = 1'b0;
            state_d = COMMIT;
          end
        end
      end

      // A failed scan also passes through here so its pulse lands one edge later.
      COMMIT: begin
        alloc_done_d = 1'b1;
        if (fit_q) begin
          alloc_ok_d   = 1'b1;
          alloc_base_d = run_start_q;
          bitmap_d     = bitmap_q & ~commit_mask;
          free_count_d = free_count_q - CW'(len_q);
        end
        state_d = IDLE;
      end

      RELEASE: begin
        cursor_d = cursor_q + FRAME_BITS'(1);
        if (rel_hit) begin
          bitmap_d[cursor_q] = 1'b1;
          free_count_d       = free_count_q + CW'(1);
          rel_cnt_d          = rel_cnt_q + CW'(1);
        end
        if (last_frame) begin
          rel_done_d  = 1'b1;
          rel_count_d = rel_cnt_d;
          state_d     = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      bitmap_q     <= '1;
      for (int i = 0; i < NUM_FRAMES; i++) tag_q[i] <= '0;
      free_count_q <= CW'(NUM_FRAMES);
      cursor_q     <= '0;
      run_start_q  <= '0;
      run_cnt_q    <= '0;
      len_q        <= '0;
      owner_q      <= '0;
      fit_q        <= 1'b0;
      rel_cnt_q    <= '0;
      alloc_done_q <= 1'b0;
      alloc_ok_q   <= 1'b0;
      alloc_base_q <= '0;
      free_done_q  <= 1'b0;
      free_ok_q    <= 1'b0;
      rel_done_q   <= 1'b0;
      rel_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      bitmap_q     <= bitmap_d;
      tag_q        <= tag_d;
      free_count_q <= free_count_d;
      cursor_q     <= cursor_d;
      run_start_q  <= run_start_d;
      run_cnt_q    <= run_cnt_d;
      len_q        <= len_d;
      owner_q      <= owner_d;
      fit_q        <= fit_d;
      rel_cnt_q    <= rel_cnt_d;
      alloc_done_q <= alloc_done_d;
      alloc_ok_q   <= alloc_ok_d;
      alloc_base_q <= alloc_base_d;
      free_done_q  <= free_done_d;
      free_ok_q    <= free_ok_d;
      rel_done_q   <= rel_done_d;
      rel_count_q  <= rel_count_d;
    end
  end

  assign ready         = (state_q == IDLE);
  assign alloc_done    = alloc_done_q;
  assign alloc_ok      = alloc_ok_q;
  assign alloc_base    = alloc_base_q;
  assign free_done     = free_done_q;
  assign free_ok       = free_ok_q;
  assign rel_done      = rel_done_q;
  assign rel_count     = rel_count_q;
  assign free_count    = free_count_q;
  assign out_of_memory = (free_count_q == '0);

endmodule

// File: tb/tb_frame_run_allocator.sv
// Scoreboard bench for frame_run_allocator: each request pushes its expected
// completion (kind, result, due edge); a negedge monitor pops and compares.
module tb_frame_run_allocator;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ready;
  logic       alloc_req = 1'b0;
  logic [3:0] alloc_len = '0;
  logic [3:0] alloc_owner = '0;
  logic       alloc_done, alloc_ok;
  logic [7:0] alloc_base;
  logic       free_req = 1'b0;
  logic [7:0] free_base = '0;
  logic [3:0] free_len = '0;
  logic [3:0] free_owner = '0;
  logic       free_done, free_ok;
  logic       rel_req = 1'b0;
  logic [3:0] rel_owner = '0;
  logic       rel_done;
  logic [8:0] rel_count, free_count;
  logic       out_of_memory;

  frame_run_allocator dut (
    .clk(clk), .rst(rst), .ready(ready),
    .alloc_req(alloc_req), .alloc_len(alloc_len), .alloc_owner(alloc_owner),
    .alloc_done(alloc_done), .alloc_ok(alloc_ok), .alloc_base(alloc_base),
    .free_req(free_req), .free_base(free_base), .free_len(free_len), .free_owner(free_owner),
    .free_done(free_done), .free_ok(free_ok),
    .rel_req(rel_req), .rel_owner(rel_owner), .rel_done(rel_done), .rel_count(rel_count),
    .free_count(free_count), .out_of_memory(out_of_memory)
  );

  always #5 clk = ~clk;

  typedef struct {
    int kind;   // 0 alloc, 1 free, 2 release
    bit ok;
    int base;
    int count;
    int due;    // edge index that sets the done pulse
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst && (alloc_done || free_done || rel_done)) begin
      int k;
      k = alloc_done ? 0 : (free_done ? 1 : 2);
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_done: kind=%0d edge=%0d, required no pulse", k, cyc);
      end else begin
        mon_e = sb.pop_front();
        if (k !== mon_e.kind || cyc !== mon_e.due || (alloc_done + free_done + rel_done) != 1) begin
          bad++;
          $display("FAIL done_timing: kind=%0d edge=%0d, required kind=%0d edge=%0d",
                   k, cyc, mon_e.kind, mon_e.due);
        end
        total++;
        if (k == 0) begin
          if (alloc_ok !== mon_e.ok || alloc_base !== 8'(mon_e.base)) begin
            bad++;
            $display("FAIL alloc_result: ok=%0b base=%0d, required ok=%0b base=%0d",
                     alloc_ok, alloc_base, mon_e.ok, mon_e.base);
          end else
            $display("alloc done edge=%0d ok=%0b base=%0d", cyc, alloc_ok, alloc_base);
        end else if (k == 1) begin
          if (free_ok !== mon_e.ok) begin
            bad++;
            $display("FAIL free_result: ok=%0b, required ok=%0b", free_ok, mon_e.ok);
          end else
            $display("free done edge=%0d ok=%0b", cyc, free_ok);
        end else begin
          if (rel_count !== 9'(mon_e.count)) begin
            bad++;
            $display("FAIL rel_count: got=%0d, required=%0d", rel_count, mon_e.count);
          end else
            $display("release done edge=%0d count=%0d", cyc, rel_count);
        end
      end
    end
  end

  task automatic wait_ready(input string name);
    for (int i = 0; i < 400 && !ready; i++) @(negedge clk);
    if (!ready) begin
      total++; bad++;
      $display("FAIL %s_ready_timeout: ready=%0b, required 1", name, ready);
    end
  endtask

  task automatic wait_empty(input string name);
    for (int i = 0; i < 400 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      total++; bad++;
      $display("FAIL %s_done_timeout: pending=%0d, required 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic alloc_op(input int len, input int owner, input bit ok, input int base, input int off);
    @(negedge clk);
    wait_ready("alloc");
    alloc_len = len[3:0];
    alloc_owner = owner[3:0];
    alloc_req = 1'b1;
    sb.push_back('{0, ok, base, 0, cyc + 1 + off});
    @(posedge clk); #1;
    alloc_req = 1'b0;
    wait_empty("alloc");
  endtask

  task automatic free_op(input int base, input int len, input int owner, input bit ok);
    @(negedge clk);
    wait_ready("free");
    free_base = base[7:0];
    free_len = len[3:0];
    free_owner = owner[3:0];
    free_req = 1'b1;
    sb.push_back('{1, ok, 0, 0, cyc + 1});
    @(posedge clk); #1;
    free_req = 1'b0;
    wait_empty("free");
  endtask

  task automatic check_fc(input string name, input int exp_fc);
    total++;
    if (free_count !== 9'(exp_fc) || out_of_memory !== (exp_fc == 0)) begin
      bad++;
      $display("FAIL %s_free_count: got=%0d oom=%0b, required=%0d oom=%0b",
               name, free_count, out_of_memory, exp_fc, exp_fc == 0);
    end else
      $display("check %s free_count=%0d", name, free_count);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (ready !== 1'b1 || alloc_done !== 1'b0 || alloc_ok !== 1'b0 || alloc_base !== 8'd0 ||
        free_done !== 1'b0 || free_ok !== 1'b0 || rel_done !== 1'b0 || rel_count !== 9'd0) begin
      bad++;
      $display("FAIL reset_outputs: ready=%0b ad=%0b ao=%0b ab=%0d fd=%0b fo=%0b rd=%0b rc=%0d, required 1 0 0 0 0 0 0 0",
               ready, alloc_done, alloc_ok, alloc_base, free_done, free_ok, rel_done, rel_count);
    end else
      $display("check reset outputs");
    check_fc("reset", 256);
  endtask

  task automatic test_alloc_basic();
    alloc_op(4, 1, 1'b1, 0, 5);
    check_fc("alloc4", 252);
    alloc_op(3, 2, 1'b1, 4, 8);
    check_fc("alloc3", 249);
  endtask

  task automatic test_free_owner();
    free_op(0, 4, 2, 1'b0);
    check_fc("free_wrong_owner", 249);
    free_op(0, 4, 1, 1'b1);
    check_fc("free_right_owner", 253);
  endtask

  task automatic test_reject();
    alloc_op(0, 1, 1'b0, 0, 0);
    alloc_op(9, 1, 1'b0, 0, 0);
    free_op(254, 4, 2, 1'b0);
    check_fc("rejects", 253);
  endtask

  task automatic test_release();
    alloc_op(4, 3, 1'b1, 0, 5);
    alloc_op(2, 5, 1'b1, 7, 10);
    alloc_op(3, 3, 1'b1, 9, 13);
    alloc_op(1, 5, 1'b1, 12, 14);
    alloc_op(3, 3, 1'b1, 13, 17);
    check_fc("pre_release", 240);
    @(negedge clk);
    wait_ready("rel");
    rel_owner = 4'd3;
    rel_req = 1'b1;
    sb.push_back('{2, 1'b1, 0, 10, cyc + 1 + 256});
    @(posedge clk); #1;
    rel_req = 1'b0;
    wait_empty("rel");
    check_fc("post_release", 250);
    free_op(7, 2, 5, 1'b1);
    free_op(12, 1, 5, 1'b1);
    free_op(0, 1, 3, 1'b0);
    check_fc("owner5_kept", 253);
  endtask

  task automatic test_fragmentation();
    alloc_op(4, 6, 1'b1, 0, 5);
    for (int i = 0; i < 31; i++) alloc_op(8, 6, 1'b1, 7 + 8 * i, 7 + 8 * i + 9);
    alloc_op(1, 6, 1'b1, 255, 257);
    check_fc("full", 0);
    alloc_op(1, 7, 1'b0, 0, 0);
    free_op(1, 1, 6, 1'b1);
    free_op(3, 1, 6, 1'b1);
    free_op(5, 1, 2, 1'b1);
    check_fc("holes", 3);
    alloc_op(2, 7, 1'b0, 0, 257);
    check_fc("frag_fail", 3);
    alloc_op(1, 7, 1'b1, 1, 3);
    check_fc("hole_fill", 2);
  endtask

  task automatic test_priority();
    @(negedge clk);
    wait_ready("prio");
    rel_owner = 4'd6; rel_req = 1'b1;
    free_base = 8'd4; free_len = 4'd1; free_owner = 4'd2; free_req = 1'b1;
    alloc_len = 4'd1; alloc_owner = 4'd8; alloc_req = 1'b1;
    sb.push_back('{2, 1'b1, 0, 251, cyc + 1 + 256});
    @(posedge clk); #1;
    rel_req = 1'b0; free_req = 1'b0; alloc_req = 1'b0;
    wait_empty("prio");
    check_fc("prio_release", 253);
  endtask

  task automatic test_reset_mid_release();
    @(negedge clk);
    wait_ready("rstrel");
    rel_owner = 4'd2;
    rel_req = 1'b1;
    @(posedge clk); #1;
    rel_req = 1'b0;
    repeat (50) @(negedge clk);
    total++;
    if (ready !== 1'b0) begin
      bad++;
      $display("FAIL mid_release_busy: ready=%0b, required 0", ready);
    end else
      $display("check release in progress");
    rst = 1'b1;
    #2;
    total++;
    if (ready !== 1'b1 || rel_count !== 9'd0) begin
      bad++;
      $display("FAIL reset_abort: ready=%0b rel_count=%0d, required 1 0", ready, rel_count);
    end else
      $display("check reset abort");
    check_fc("reset_abort", 256);
    @(negedge clk);
    rst = 1'b0;
    repeat (300) @(negedge clk);
    check_fc("after_abort", 256);
  endtask

  initial begin
    test_reset();
    test_alloc_basic();
    test_free_owner();
    test_reject();
    test_release();
    test_fragmentation();
    test_priority();
    test_reset_mid_release();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
